kbd_event_ctrl: RTL
===================

KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, event FIFO depth (power of 2, 2..64).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port rx_data, input, 8, byte from the PS/2 receiver.
REQ-005 The block SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-006 The block SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-007 The block SHALL have port clr_ovf, input, 1, clears the overflow flag.
REQ-008 The block SHALL have port evt_valid, output, 1, head event present.
REQ-009 The block SHALL have port evt_code, output, 8, scan code of the head event.
REQ-010 The block SHALL have port evt_ext, output, 1, head event carried an E0 prefix.
REQ-011 The block SHALL have port evt_break, output, 1, head event is a release; 0 means press.
REQ-012 The block SHALL have port evt_mods, output, 2, {ctrl, shift} state after the head event was applied.
REQ-013 The block SHALL have port fifo_level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-014 The block SHALL have port ovf, output, 1, sticky flag: an event was dropped.

Function
REQ-015 The decoder SHALL have four states: IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-016 Transitions on rx_valid: IDLE --E0--> EXT, IDLE --F0--> BRK, EXT --F0--> EXT_BRK; any other byte completes an event and returns to IDLE.
REQ-017 In IDLE, bytes 00, AA, EE, FA, FE, FF and E1 SHALL be discarded with no event and no state change.
REQ-018 A completed event SHALL be {code=byte, ext=(state is EXT or EXT_BRK), break=(state is BRK or EXT_BRK)}.
REQ-019 Modifiers: shift is set on a make of 12 or 59 (non-ext) and cleared on the matching break; ctrl is set on a make of 14 (ext or non-ext) and cleared on its break; mods SHALL reflect the update made by the same event.
REQ-020 Event write latency: an event completed by rx_valid in cycle N SHALL be written at the edge ending cycle N; evt_valid SHALL be high in cycle N+1.
REQ-021 Handshake: the head event SHALL be popped at an edge where evt_valid and evt_ready are both high, and outputs SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-022 If push and pop occur in the same cycle while full, both SHALL succeed; level SHALL be unchanged and no overflow SHALL be raised.
REQ-023 If push occurs while full with no pop, the new event SHALL be dropped, FIFO contents SHALL be unchanged and ovf SHALL be set.
REQ-024 ovf SHALL be cleared by clr_ovf; if clr_ovf coincides with a drop, ovf SHALL remain set.
REQ-025 evt_ready while empty SHALL have no effect; pointers SHALL wrap modulo DEPTH.
REQ-026 Modifier state SHALL update even when the event is dropped.
REQ-027 When evt_valid=0, evt_code, evt_ext, evt_break and evt_mods SHALL be 0.

Reset
REQ-028 On reset: state=IDLE, FIFO empty, fifo_level=0, evt_valid=0, evt_*=0, mods=0, ovf=0; reset asserted mid-sequence (e.g., after E0) SHALL discard the partial prefix.

Configuration
REQ-029 With KBD_TYPEMATIC_FILTER_EN defined, a make whose {ext,code} equals the last held make SHALL be dropped (no FIFO write, no ovf); a break of that key SHALL clear the held record, as SHALL reset.
REQ-030 Without KBD_TYPEMATIC_FILTER_EN, every make SHALL be forwarded, and no held-key register SHALL exist.

Structure
REQ-031 Package kbd_pkg SHALL hold the decoder state enum, the prefix constants (E0, F0, E1), the ignored-byte constants, the modifier codes and the packed event type {mods, ext, brk, code}.
REQ-032 The FIFO SHALL be the sub-module kbd_evt_fifo (parameter DEPTH; push/pop/full/empty/level).

Verification
REQ-033 Bytes 1C; F0 1C with evt_ready=1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; evt_valid high in the cycle after each final byte.
REQ-034 Bytes 12, 1C, F0 12 -> mods=01 on the first two events; the third event {12,brk1} shows mods=00.
REQ-035 Bytes E0 75, E0 F0 75 -> {75,ext1,brk0}, {75,ext1,brk1}; E0 then rst then 75 -> {75,ext0}.
REQ-036 DEPTH=8, evt_ready=0, 9 makes -> level=8, ovf=1, head=first event; then a 10th make with evt_ready=1 -> level stays 8, ovf unchanged; clr_ovf -> ovf=0.
REQ-037 Bytes AA, FA, 00 -> no event; level=0.
REQ-038 With KBD_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C -> exactly 2 events; without the macro: 4 events.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event controller.
// Optional typematic-repeat filter in kbd_event_ctrl is enabled by KBD_TYPEMATIC_FILTER_EN.
package kbd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } kbd_state_e;

    localparam logic [7:0] PrefixExt   = 8'hE0;
    localparam logic [7:0] PrefixBrk   = 8'hF0;
    localparam logic [7:0] PrefixPause = 8'hE1;

    localparam logic [7:0] IgnNull   = 8'h00;
    localparam logic [7:0] IgnBatOk  = 8'hAA;
    localparam logic [7:0] IgnEcho   = 8'hEE;
    localparam logic [7:0] IgnAck    = 8'hFA;
    localparam logic [7:0] IgnResend = 8'hFE;
    localparam logic [7:0] IgnError  = 8'hFF;

    localparam logic [7:0] KeyShiftL = 8'h12;
    localparam logic [7:0] KeyShiftR = 8'h59;
    localparam logic [7:0] KeyCtrl   = 8'h14;

    typedef struct packed {
        logic [1:0] mods;  // {ctrl, shift}
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    // Controller status/response bytes that never start a key sequence.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == IgnNull) || (b == IgnBatOk) || (b == IgnEcho) || (b == IgnAck) ||
               (b == IgnResend) || (b == IgnError) || (b == PrefixPause);
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Event FIFO for kbd_event_ctrl; a push while full is accepted only when a pop frees a slot.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  kbd_evt_t      wdata_i,
    input  logic          pop_i,
    output kbd_evt_t      rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    kbd_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign cnt_d   = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = cnt_q;

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code decoder with modifier tracking and an event FIFO.
// Define KBD_TYPEMATIC_FILTER_EN to drop auto-repeat makes of the currently held key.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     evt_ready,
    input  logic                     clr_ovf,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_break,
    output logic [1:0]               evt_mods,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf
);

    kbd_state_e state_q, state_d;
    logic       shift_q, shift_d, ctrl_q, ctrl_d, ovf_q, ovf_d;
    logic       complete, ev_ext, ev_brk, repeat_make, push, pop, drop;
    logic       fifo_full, fifo_empty;
    kbd_evt_t   evt_new, head;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        ctrl_d   = ctrl_q;
        complete = 1'b0;
        ev_ext   = (state_q == StExt) || (state_q == StExtBrk);
        ev_brk   = (state_q == StBrk) || (state_q == StExtBrk);
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (!is_ignored(rx_data)) begin
                        if (rx_data == PrefixExt)      state_d = StExt;
                        else if (rx_data == PrefixBrk) state_d = StBrk;
                        else                           complete = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_data == PrefixBrk) state_d = StExtBrk;
                    else                      complete = 1'b1;
                end
                default: complete = 1'b1;
            endcase
        end
        if (complete) begin
            state_d = StIdle;
            if (!ev_ext && (rx_data == KeyShiftL || rx_data == KeyShiftR)) shift_d = !ev_brk;
            if (rx_data == KeyCtrl) ctrl_d = !ev_brk;
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic       held_vld_q, held_vld_d;
    logic [8:0] held_key_q, held_key_d;

    assign repeat_make = complete && !ev_brk && held_vld_q && (held_key_q == {ev_ext, rx_data});

    always_comb begin
        held_vld_d = held_vld_q;
        held_key_d = held_key_q;
        if (complete && !ev_brk) begin
            held_vld_d = 1'b1;
            held_key_d = {ev_ext, rx_data};
        end else if (complete && ev_brk && (held_key_q == {ev_ext, rx_data})) begin
            held_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_vld_q <= 1'b0;
            held_key_q <= '0;
        end else begin
            held_vld_q <= held_vld_d;
            held_key_q <= held_key_d;
        end
    end
`else
    assign repeat_make = 1'b0;
`endif

    assign push    = complete && !repeat_make;
    assign pop     = evt_ready && !fifo_empty;
    assign drop    = push && fifo_full && !pop;
    assign evt_new = '{mods: {ctrl_d, shift_d}, ext: ev_ext, brk: ev_brk, code: rx_data};
    // A drop in the same cycle as a clear wins, so no lost event goes unreported.
    assign ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= 1'b0;
            ctrl_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (evt_new),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = evt_valid ? head.code : 8'h00;
    assign evt_ext   = evt_valid && head.ext;
    assign evt_break = evt_valid && head.brk;
    assign evt_mods  = evt_valid ? head.mods : 2'b00;
    assign ovf       = ovf_q;

endmodule
